cmos_capture_ctrl: RTL and testbench

Capture sequencer in the cmos_pclk domain, between the OV5640 pixel stream (ov5640_top) and the FIFO HS write port.
- Holds off until camera configuration is done, then discards SKIP_FRAMES settling frames.
- Gates pixel writes to whole frames only, in single-shot or continuous mode.
- Aborts a frame on FIFO back-pressure.
- Publishes per-frame pixel/line statistics and status for PMOD/UART debug.

---
 rtl/cmos_capture_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_cmos_capture_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_capture_ctrl.sv
// Capture sequencer in the cmos_pclk domain: waits for sensor configuration, discards settling frames,
// passes whole frames to the FIFO HS write port and publishes per-frame statistics.
module cmos_capture_ctrl #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SKIP_FRAMES = 4
) (
   input  logic        cmos_pclk,
   input  logic        I_rst_n,
   input  logic        I_cfg_done,
   input  logic        I_vsync,
   input  logic        I_href,
   input  logic        I_wr_en,
   input  logic [15:0] I_data,
   input  logic        I_fifo_almost_full,
   input  logic        I_capture_req,
   input  logic        I_continuous,
   output logic        O_fifo_wr_en,
   output logic [15:0] O_fifo_data,
   output logic        O_frame_start,
   output logic        O_frame_done,
   output logic        O_frame_ok,
   output logic [19:0] O_pix_count,
   output logic [11:0] O_line_count,
   output logic [7:0]  O_overflow_cnt,
   output logic [2:0]  O_state,
   output logic        O_busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SKIP    = 3'd1,
      ARMED   = 3'd2,
      CAPTURE = 3'd3,
      DROP    = 3'd4
   } state_t;

   localparam logic [19:0] PIX_FULL  = 20'(H_ACTIVE * V_ACTIVE);
   localparam logic [11:0] LINE_FULL = 12'(V_ACTIVE);
   localparam logic [7:0]  SKIP_LAST = 8'(SKIP_FRAMES);

   state_t      r_state;
   state_t      w_next;
   logic        r_vsync_d;
   logic        r_href_d;
   logic        r_req_pend;
   logic        r_abort;
   logic [7:0]  r_skip_cnt;
   logic [19:0] r_pix_cnt;
   logic [11:0] r_line_cnt;
   logic        r_fifo_wr_en;
   logic [15:0] r_fifo_data;
   logic        r_frame_start;
   logic        r_frame_done;
   logic        r_frame_ok;
   logic [19:0] r_pix_out;
   logic [11:0] r_line_out;
   logic [7:0]  r_ovf_cnt;

   logic        w_vs_fall;
   logic        w_vs_rise;
   logic        w_hs_fall;
   logic        w_start;
   logic        w_write;
   logic        w_abort;
   logic        w_final;
   logic        w_line_inc;
   logic        w_skip_inc;
   logic        w_skip_clr;
   logic        w_abort_fin;
   logic [19:0] w_pix_next;
   logic [11:0] w_line_next;

   assign w_vs_fall = r_vsync_d & ~I_vsync;
   assign w_vs_rise = ~r_vsync_d & I_vsync;
   assign w_hs_fall = r_href_d & ~I_href;

   always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
      if (!I_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Losing configuration overrides every other event so no write or finalize leaks out.
   always_comb begin
      w_next     = r_state;
      w_start    = 1'b0;
      w_write    = 1'b0;
      w_abort    = 1'b0;
      w_final    = 1'b0;
      w_line_inc = 1'b0;
      w_skip_inc = 1'b0;
      w_skip_clr = 1'b0;
      if (r_state != IDLE && !I_cfg_done) begin
         w_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (I_cfg_done) begin
                  w_skip_clr = 1'b1;
                  w_next     = (SKIP_FRAMES == 0) ? ARMED : SKIP;
               end
            end
            SKIP: begin
               if (r_skip_cnt == SKIP_LAST) w_next = ARMED;
               else if (w_vs_rise)          w_skip_inc = 1'b1;
            end
            ARMED: begin
               if (w_vs_fall && (I_continuous || r_req_pend || I_capture_req)) begin
                  w_start = 1'b1;
                  w_next  = CAPTURE;
               end
            end
            CAPTURE: begin
               w_line_inc = w_hs_fall;
               if (I_wr_en && !I_fifo_almost_full) w_write = 1'b1;
               if (I_wr_en && I_fifo_almost_full) begin
                  w_abort = 1'b1;
                  w_next  = DROP;
               end
               if (w_vs_rise) begin
                  w_final = 1'b1;
                  w_next  = ARMED;
               end
            end
            DROP: begin
               w_line_inc = w_hs_fall;
               if (w_vs_rise) begin
                  w_final = 1'b1;
                  w_next  = ARMED;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   // A pixel or line end coinciding with vsync rise still belongs to the finishing frame.
   assign w_pix_next  = (w_write && r_pix_cnt != 20'hFFFFF) ? r_pix_cnt + 20'd1 : r_pix_cnt;
   assign w_line_next = (w_line_inc && r_line_cnt != 12'hFFF) ? r_line_cnt + 12'd1 : r_line_cnt;
   assign w_abort_fin = r_abort | w_abort;

   always_ff @(posedge cmos_pclk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_vsync_d     <= 1'b0;
         r_href_d      <= 1'b0;
         r_req_pend    <= 1'b0;
         r_abort       <= 1'b0;
         r_skip_cnt    <= 8'd0;
         r_pix_cnt     <= 20'd0;
         r_line_cnt    <= 12'd0;
         r_fifo_wr_en  <= 1'b0;
         r_fifo_data   <= 16'd0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_ok    <= 1'b0;
         r_pix_out     <= 20'd0;
         r_line_out    <= 12'd0;
         r_ovf_cnt     <= 8'd0;
      end else begin
         r_vsync_d     <= I_vsync;
         r_href_d      <= I_href;
         r_fifo_wr_en  <= w_write;
         r_frame_start <= w_start;
         r_frame_done  <= w_final;
         if (w_write) r_fifo_data <= I_data;

         if (w_skip_clr)      r_skip_cnt <= 8'd0;
         else if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 8'd1;

         if (w_start)            r_req_pend <= 1'b0;
         else if (I_capture_req) r_req_pend <= 1'b1;

         if (w_start) begin
            r_pix_cnt  <= 20'd0;
            r_line_cnt <= 12'd0;
            r_abort    <= 1'b0;
         end else begin
            r_pix_cnt  <= w_pix_next;
            r_line_cnt <= w_line_next;
            if (w_final)      r_abort <= 1'b0;
            else if (w_abort) r_abort <= 1'b1;
         end

         if (w_final) begin
            r_pix_out  <= w_pix_next;
            r_line_out <= w_line_next;
            r_frame_ok <= ~w_abort_fin & (w_pix_next == PIX_FULL) & (w_line_next == LINE_FULL);
            if (w_abort_fin && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
         end
      end
   end

   assign O_fifo_wr_en   = r_fifo_wr_en;
   assign O_fifo_data    = r_fifo_data;
   assign O_frame_start  = r_frame_start;
   assign O_frame_done   = r_frame_done;
   assign O_frame_ok     = r_frame_ok;
   assign O_pix_count    = r_pix_out;
   assign O_line_count   = r_line_out;
   assign O_overflow_cnt = r_ovf_cnt;
   assign O_state        = r_state;
   assign O_busy         = (r_state == CAPTURE) || (r_state == DROP);

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Directed-plus-random bench for cmos_capture_ctrl; a frame-level model predicts which frames are
// captured, the exact words written and the published statistics.
module tb_cmos_capture_ctrl;

   localparam int H    = 16;
   localparam int V    = 6;
   localparam int SKIP = 2;
   localparam int P    = H * V;

   logic        cmos_pclk = 1'b0;
   logic        I_rst_n;
   logic        I_cfg_done;
   logic        I_vsync;
   logic        I_href;
   logic        I_wr_en;
   logic [15:0] I_data;
   logic        I_fifo_almost_full;
   logic        I_capture_req;
   logic        I_continuous;
   logic        O_fifo_wr_en;
   logic [15:0] O_fifo_data;
   logic        O_frame_start;
   logic        O_frame_done;
   logic        O_frame_ok;
   logic [19:0] O_pix_count;
   logic [11:0] O_line_count;
   logic [7:0]  O_overflow_cnt;
   logic [2:0]  O_state;
   logic        O_busy;

   cmos_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
      .cmos_pclk          (cmos_pclk),
      .I_rst_n            (I_rst_n),
      .I_cfg_done         (I_cfg_done),
      .I_vsync            (I_vsync),
      .I_href             (I_href),
      .I_wr_en            (I_wr_en),
      .I_data             (I_data),
      .I_fifo_almost_full (I_fifo_almost_full),
      .I_capture_req      (I_capture_req),
      .I_continuous       (I_continuous),
      .O_fifo_wr_en       (O_fifo_wr_en),
      .O_fifo_data        (O_fifo_data),
      .O_frame_start      (O_frame_start),
      .O_frame_done       (O_frame_done),
      .O_frame_ok         (O_frame_ok),
      .O_pix_count        (O_pix_count),
      .O_line_count       (O_line_count),
      .O_overflow_cnt     (O_overflow_cnt),
      .O_state            (O_state),
      .O_busy             (O_busy)
   );

   always #5 cmos_pclk = ~cmos_pclk;

   logic [63:0] allOut;
   assign allOut = {O_fifo_wr_en, O_fifo_data, O_frame_start, O_frame_done, O_frame_ok,
                    O_pix_count, O_line_count, O_overflow_cnt, O_state, O_busy};

   int errors = 0;
   int checks = 0;

   // Observed FIFO traffic and pulses, collected away from the active edge.
   logic [15:0] gotData[$];
   int          startSeen = 0;
   int          doneSeen = 0;
   int          violations = 0;
   logic [2:0]  prevState = 3'd0;

   always @(negedge cmos_pclk) begin
      if (O_fifo_wr_en) begin
         gotData.push_back(O_fifo_data);
         if (prevState !== 3'd3) violations++;
      end
      if (O_frame_start) startSeen++;
      if (O_frame_done) doneSeen++;
      prevState = O_state;
   end

   // Frame-level reference model.
   bit mCfg = 0;
   bit mReq = 0;
   bit mOk = 0;
   int mSkipLeft = SKIP;
   int mPix = 0;
   int mLine = 0;
   int mOverflow = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge cmos_pclk);
      #1;
   endtask

   task automatic setCfg();
      I_cfg_done = 1'b1;
      if (!mCfg) begin
         mCfg = 1;
         mSkipLeft = SKIP;
      end
      step();
      step();
   endtask

   // Drives one frame (lines of H pixels) and checks the frame's outcome against the model.
   // Event positions are 1-based pixel indices; 0 means the event does not happen.
   task automatic applyStimulus(input int lines, input int abortAt, input int cfgDropAt,
                                input int rstAt, input int reqA, input int reqB, input bit reqAtFall);
      bit captured;
      bit stopped = 0;
      bit aborted = 0;
      bit dropped = 0;
      bit resetHit = 0;
      bit expDone = 0;
      bit same;
      int pixIdx = 0;
      int expState;
      logic [15:0] expQ[$];

      gotData.delete();
      startSeen = 0;
      doneSeen = 0;
      captured = mCfg && (mSkipLeft == 0) && (I_continuous || mReq || reqAtFall);
      if (captured) mReq = 0;
      else if (reqAtFall) mReq = 1;

      I_vsync = 1'b0;
      I_capture_req = reqAtFall;
      step();
      I_capture_req = 1'b0;
      step();
      step();

      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < H; p++) begin
            if ($urandom_range(0, 2) == 0) begin
               I_href = 1'b1;
               I_wr_en = 1'b0;
               step();
            end
            pixIdx++;
            I_href = 1'b1;
            I_wr_en = 1'b1;
            I_data = 16'($urandom);
            if (pixIdx == abortAt) I_fifo_almost_full = 1'b1;
            if (pixIdx == cfgDropAt) begin
               I_cfg_done = 1'b0;
               dropped = 1;
            end
            if (pixIdx == reqA || pixIdx == reqB) begin
               I_capture_req = 1'b1;
               mReq = 1;
            end
            if (captured && !stopped) begin
               if (!I_cfg_done) stopped = 1;
               else if (I_fifo_almost_full) begin
                  stopped = 1;
                  aborted = 1;
               end else expQ.push_back(I_data);
            end
            step();
            I_wr_en = 1'b0;
            I_capture_req = 1'b0;
            if (pixIdx == cfgDropAt) begin
               checkOutput("cfgdrop_wr_en", 64'(O_fifo_wr_en), 64'd0);
               checkOutput("cfgdrop_state", 64'(O_state), 64'd0);
            end
            if (pixIdx == abortAt && aborted) begin
               checkOutput("abort_state", 64'(O_state), 64'd4);
               checkOutput("abort_busy", 64'(O_busy), 64'd1);
            end
            if (pixIdx == rstAt) begin
               @(negedge cmos_pclk);
               #1;
               I_rst_n = 1'b0;
               I_cfg_done = 1'b0;
               #1;
               checkOutput("async_reset_outputs", allOut, 64'd0);
               I_rst_n = 1'b1;
               resetHit = 1;
               stopped = 1;
               mCfg = 0;
               mReq = 0;
               mOk = 0;
               mPix = 0;
               mLine = 0;
               mOverflow = 0;
               mSkipLeft = SKIP;
               step();
               checkOutput("reset_release_idle", 64'(O_state), 64'd0);
            end
         end
         I_href = 1'b0;
         step();
         step();
      end

      I_vsync = 1'b1;
      step();
      repeat (4) step();
      I_fifo_almost_full = 1'b0;

      if (resetHit) begin
      end else if (dropped) begin
         mCfg = 0;
         mSkipLeft = SKIP;
      end else if (captured) begin
         expDone = 1;
         mPix = expQ.size();
         mLine = lines;
         mOk = !aborted && (mPix == P) && (lines == V);
         if (aborted && mOverflow < 255) mOverflow++;
      end else if (mCfg && mSkipLeft > 0) begin
         mSkipLeft--;
      end

      same = (gotData.size() == expQ.size());
      if (same) begin
         for (int i = 0; i < expQ.size(); i++)
            if (gotData[i] !== expQ[i]) same = 0;
      end
      if (!mCfg) expState = 0;
      else if (mSkipLeft > 0) expState = 1;
      else expState = 2;

      checkOutput("write_count", 64'(gotData.size()), 64'(expQ.size()));
      checkOutput("write_data_match", 64'(same), 64'd1);
      checkOutput("frame_start_pulses", 64'(startSeen), 64'(captured));
      checkOutput("frame_done_pulses", 64'(doneSeen), 64'(expDone));
      checkOutput("pix_count", 64'(O_pix_count), 64'(mPix));
      checkOutput("line_count", 64'(O_line_count), 64'(mLine));
      checkOutput("frame_ok", 64'(O_frame_ok), 64'(mOk));
      checkOutput("overflow_cnt", 64'(O_overflow_cnt), 64'(mOverflow));
      checkOutput("state_after_frame", 64'(O_state), 64'(expState));
   endtask

   initial begin
      I_rst_n = 1'b0;
      I_cfg_done = 1'b0;
      I_vsync = 1'b1;
      I_href = 1'b0;
      I_wr_en = 1'b0;
      I_data = 16'd0;
      I_fifo_almost_full = 1'b0;
      I_capture_req = 1'b0;
      I_continuous = 1'b1;
      repeat (3) step();
      checkOutput("reset_outputs", allOut, 64'd0);
      I_rst_n = 1'b1;
      step();
      step();
      checkOutput("idle_without_cfg", 64'(O_state), 64'd0);

      // Startup: settling frames skipped, then continuous capture.
      setCfg();
      checkOutput("skip_after_cfg", 64'(O_state), 64'd1);
      for (int f = 0; f < SKIP + 2; f++) applyStimulus(V, 0, 0, 0, 0, 0, 0);

      // Single-shot: request mid-frame, duplicate requests, request coinciding with vsync fall.
      I_continuous = 1'b0;
      applyStimulus(V, 0, 0, 0, 20, 0, 0);
      applyStimulus(V, 0, 0, 0, 0, 0, 0);
      applyStimulus(V, 0, 0, 0, 0, 0, 0);
      applyStimulus(V, 0, 0, 0, 5, 60, 0);
      applyStimulus(V, 0, 0, 0, 0, 0, 0);
      applyStimulus(V, 0, 0, 0, 0, 0, 1);
      applyStimulus(V, 0, 0, 0, 0, 0, 0);

      // Back-pressure abort, recovery, short frame.
      I_continuous = 1'b1;
      applyStimulus(V, 40, 0, 0, 0, 0, 0);
      applyStimulus(V, 0, 0, 0, 0, 0, 0);
      applyStimulus(V - 1, 0, 0, 0, 0, 0, 0);

      // Configuration lost mid-capture, then the skip sequence restarts.
      applyStimulus(V, 0, 50, 0, 0, 0, 0);
      setCfg();
      for (int f = 0; f < SKIP + 1; f++) applyStimulus(V, 0, 0, 0, 0, 0, 0);

      // Asynchronous reset in the middle of a captured frame.
      applyStimulus(V, 0, 0, 30, 0, 0, 0);
      setCfg();

      // Randomised frames.
      for (int f = 0; f < 14; f++) begin
         int ln;
         int ab;
         int ra;
         I_continuous = 1'($urandom_range(0, 1));
         ln = ($urandom_range(0, 4) == 0) ? V - 1 : V;
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, P)) : 0;
         ra = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, P - H)) : 0;
         applyStimulus(ln, ab, 0, 0, ra, 0, 1'($urandom_range(0, 3) == 0));
      end

      checkOutput("wr_outside_capture", 64'(violations), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
